// File: rtl/char_draw_arbiter_pkg.sv
// char_draw_arbiter_pkg: shared FSM states, widths and timeout default for the character draw arbiter.
package char_draw_arbiter_pkg;
    localparam int ASCII_W         = 7;
    localparam int COORD_W         = 9;
    localparam int CNT_W           = 16;
    localparam int TIMEOUT_CYC_DEF = 4096;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
endpackage

// File: rtl/char_draw_arbiter_if.sv
// char_draw_arbiter_if: renderer-side bus between the arbiter (master) and the character renderer (slave).
interface char_draw_arbiter_if;
    import char_draw_arbiter_pkg::*;
    logic               show_char_flag;
    logic               show_char_done;
    logic               en_size;
    logic [ASCII_W-1:0] ascii_num;
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    modport master (output show_char_flag, en_size, ascii_num, start_x, start_y, input show_char_done);
    modport slave  (input show_char_flag, en_size, ascii_num, start_x, start_y, output show_char_done);
endinterface

// File: rtl/char_draw_arbiter.sv
// char_draw_arbiter: round-robin arbiter granting two character-draw requesters access to one LCD renderer.
module char_draw_arbiter
    import char_draw_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               init_done,
    input  logic               req0_valid,
    input  logic [ASCII_W-1:0] req0_ascii,
    input  logic [COORD_W-1:0] req0_x,
    input  logic [COORD_W-1:0] req0_y,
    output logic               req0_ack,
    output logic               req0_done,
    input  logic               req1_valid,
    input  logic [ASCII_W-1:0] req1_ascii,
    input  logic [COORD_W-1:0] req1_x,
    input  logic [COORD_W-1:0] req1_y,
    output logic               req1_ack,
    output logic               req1_done,
    char_draw_arbiter_if.master lcd,
    output logic               busy,
    output logic               err_timeout
);
    state_t           state;
    logic             ptr;
    logic             gnt;
    logic             win;
    logic [CNT_W-1:0] cnt;
    logic             term;
    // ptr only matters under contention; a lone valid always wins
    assign win       = (req0_valid && req1_valid) ? ptr : req1_valid;
    assign term      = cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign busy      = state != S_IDLE;
    assign lcd.en_size = 1'b1;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state              <= S_IDLE;
            ptr                <= 1'b0;
            gnt                <= 1'b0;
            cnt                <= '0;
            lcd.ascii_num      <= '0;
            lcd.start_x        <= '0;
            lcd.start_y        <= '0;
            lcd.show_char_flag <= 1'b0;
            req0_ack           <= 1'b0;
            req1_ack           <= 1'b0;
            req0_done          <= 1'b0;
            req1_done          <= 1'b0;
            err_timeout        <= 1'b0;
        end else begin
            lcd.show_char_flag <= 1'b0;
            req0_ack           <= 1'b0;
            req1_ack           <= 1'b0;
            req0_done          <= 1'b0;
            req1_done          <= 1'b0;
            err_timeout        <= 1'b0;
            case (state)
                S_IDLE: if (init_done && (req0_valid || req1_valid)) begin
                    gnt                <= win;
                    lcd.ascii_num      <= win ? req1_ascii : req0_ascii;
                    lcd.start_x        <= win ? req1_x : req0_x;
                    lcd.start_y        <= win ? req1_y : req0_y;
                    lcd.show_char_flag <= 1'b1;
                    req0_ack           <= !win;
                    req1_ack           <= win;
                    state              <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: if (lcd.show_char_done || term) begin
                    // a done on the terminal count wins over the abort
                    req0_done   <= !gnt;
                    req1_done   <= gnt;
                    err_timeout <= !lcd.show_char_done;
                    ptr         <= !gnt;
                    state       <= S_IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_char_draw_arbiter.sv
// tb_char_draw_arbiter: randomized requesters and renderer checked cycle by cycle against a deadline-based reference model.
module tb_char_draw_arbiter;
    import char_draw_arbiter_pkg::*;
    localparam int TO = 8;
    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic               init_done = 1'b0;
    logic               v [2];
    logic [ASCII_W-1:0] a [2];
    logic [COORD_W-1:0] x [2];
    logic [COORD_W-1:0] y [2];
    logic               req0_ack, req1_ack, req0_done, req1_done, busy, err_timeout;
    char_draw_arbiter_if lcd();
    always #5 sys_clk = ~sys_clk;
    char_draw_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done),
        .req0_valid(v[0]), .req0_ascii(a[0]), .req0_x(x[0]), .req0_y(y[0]),
        .req0_ack(req0_ack), .req0_done(req0_done),
        .req1_valid(v[1]), .req1_ascii(a[1]), .req1_x(x[1]), .req1_y(y[1]),
        .req1_ack(req1_ack), .req1_done(req1_done),
        .lcd(lcd.master), .busy(busy), .err_timeout(err_timeout)
    );
    int total = 0;
    int bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Reference: a transaction granted at edge g owns the renderer until a done
    // arrives after the issue cycle, or until its deadline edge g+1+TO.
    int       edge_n = 0;
    int       g_edge = 0;
    bit       tx = 0;
    bit       owner = 0;
    bit       fav = 0;
    bit [1:0] e_ack, e_done;
    bit       e_flag, e_err;
    int       m_ascii, m_x, m_y;
    task automatic model_step();
        edge_n++;
        e_ack = 0; e_done = 0; e_flag = 0; e_err = 0;
        if (sys_rst) begin
            tx = 0; fav = 0; m_ascii = 0; m_x = 0; m_y = 0;
        end else if (tx) begin
            if (edge_n >= g_edge + 2 && (lcd.show_char_done || edge_n == g_edge + 1 + TO)) begin
                e_done[owner] = 1;
                e_err = !lcd.show_char_done;
                fav = !owner;
                tx = 0;
            end
        end else if (init_done && (v[0] || v[1])) begin
            owner = (v[0] && v[1]) ? fav : (v[1] ? 1'b1 : 1'b0);
            m_ascii = a[owner]; m_x = x[owner]; m_y = y[owner];
            e_flag = 1;
            e_ack[owner] = 1;
            g_edge = edge_n;
            tx = 1;
        end
    endtask
    initial begin
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; a[i] = 0; x[i] = 0; y[i] = 0;
        end
        lcd.show_char_done = 0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge sys_clk);
            model_step();
            #1;
            chk("flag", lcd.show_char_flag, e_flag);
            chk("ack0", req0_ack, e_ack[0]);
            chk("ack1", req1_ack, e_ack[1]);
            chk("done0", req0_done, e_done[0]);
            chk("done1", req1_done, e_done[1]);
            chk("err", err_timeout, e_err);
            chk("busy", busy, tx);
            chk("ascii", lcd.ascii_num, m_ascii);
            chk("sx", lcd.start_x, m_x);
            chk("sy", lcd.start_y, m_y);
            chk("en", lcd.en_size, 1);
            sys_rst = (n < 2) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 29) == 0) init_done = !init_done;
            lcd.show_char_done = $urandom_range(0, 5) == 0;
            for (int i = 0; i < 2; i++) begin
                if (e_ack[i] || !v[i]) begin
                    v[i] = e_ack[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
                    a[i] = ASCII_W'($urandom);
                    x[i] = COORD_W'($urandom);
                    y[i] = COORD_W'($urandom);
                end else if ($urandom_range(0, 31) == 0) begin
                    v[i] = 0;
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
